instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  request carries a field set.
REQ-005 in_ready  output  1  encoder accepts the request this cycle.
REQ-006 kind  input  3  instruction class: 0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J; 6 and 7 illegal.
REQ-007 rs, rt, rd  input  5 each  register fields.
REQ-008 funct  input  6  R-type function field.
REQ-009 imm  input  16  I-type immediate.
REQ-010 target  input  26  J-type target.
REQ-011 base_load  input  1  load the address counter from base_addr.
REQ-012 base_addr  input  32  new byte address; bits [1:0] are ignored and treated as 0.
REQ-013 out_valid  output  1  out_instr and out_addr are valid.
REQ-014 out_ready  input  1  consumer takes the output.
REQ-015 out_instr  output  32  encoded instruction word.
REQ-016 out_addr  output  32  byte address of out_instr.
REQ-017 err  output  1  one-cycle pulse when an illegal kind is accepted.
REQ-018 err_count  output  8  count of illegal requests, saturating.

Function
REQ-019 Opcode field [31:26] SHALL be: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
REQ-020 R-type SHALL pack {op, rs, rt, rd, 5'b0, funct}.
REQ-021 LW, SW, BEQ and ADDI SHALL pack {op, rs, rt, imm}; rd and funct are ignored.
REQ-022 J SHALL pack {op, target}; all other fields are ignored.
REQ-023 Output stage SHALL be a single register; in_ready = !out_valid || out_ready.
REQ-024 A request is accepted when in_valid && in_ready. A legal accepted request SHALL appear on out_instr/out_addr with out_valid=1 on the next cycle (latency 1).
REQ-025 Full throughput SHALL be one instruction per cycle while out_ready=1.
REQ-026 While out_valid && !out_ready, out_instr, out_addr and out_valid SHALL hold stable.
REQ-027 out_valid SHALL drop on the cycle after a transfer (out_valid && out_ready) unless a new request is accepted in that same cycle.
REQ-028 Address counter pc_next SHALL give each emitted word its address, then advance by 4, wrapping 0xFFFFFFFC -> 0x00000000.
REQ-029 base_load in a cycle with no accept SHALL set pc_next = base_addr.
REQ-030 base_load in the same cycle as an accept SHALL give the accepted word out_addr = base_addr and set pc_next = base_addr + 4.
REQ-031 base_load SHALL NOT alter an output word that is already held.
REQ-032 An illegal kind that is accepted SHALL be consumed without output: out_valid, the output registers and pc_next are unchanged, err=1 for one cycle, and err_count increments, saturating at 255.
REQ-033 in_ready SHALL depend only on the register state and out_ready, with no combinational path from in_valid.

Reset
REQ-034 When rst_n=0 at a clock edge, the block SHALL set out_valid=0, out_instr=0, out_addr=0, pc_next=0, err=0 and err_count=0.
REQ-035 Reset SHALL take priority over every other input. A held word is discarded on reset mid-handshake, and in_ready=1 on the first cycle after reset.

Structure
REQ-036 Opcode constants and the kind encoding SHALL live in the shared package mips_pkg, which the decoders also use.
REQ-037 Word packing SHALL be a combinational sub-module instr_pack (kind plus fields in, 32-bit word and illegal flag out). The handshake, counter and error logic SHALL be in instr_encoder.

Verification
REQ-038 ADDI: rs=1, rt=2, imm=0x0005 after reset -> out_instr=0x20220005, out_addr=0x00000000.
REQ-039 RTYPE: rs=1, rt=2, rd=3, funct=0x20, then LW: rs=29, rt=8, imm=4, sent back to back with out_ready=1 -> 0x00221820 @0x0 and then 0x8FA80004 @0x4 on consecutive cycles.
REQ-040 J with target=0x0000010 and out_ready=0 for 3 cycles -> 0x08000010 held stable, in_ready=0; releases on the cycle out_ready rises.
REQ-041 base_load with base_addr=0xFFFFFFFC together with a BEQ accept, then one further accept -> addresses 0xFFFFFFFC then 0x00000000.
REQ-042 kind=7 accepted -> err pulses for 1 cycle, err_count=1, no out_valid, next legal word keeps the prior address; 300 illegal requests -> err_count=255.
REQ-043 rst_n=0 while a word is held with out_ready=0 -> out_valid=0 and pc_next=0 on the next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: instruction classes and primary opcodes.
// Used by the encoder here and by the decoders elsewhere in the codebase.
package mips_pkg;

    typedef enum logic [2:0] {
        KIND_RTYPE = 3'd0,
        KIND_LW    = 3'd1,
        KIND_SW    = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ADDI  = 3'd4,
        KIND_J     = 3'd5
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] ADDR_STEP = 32'd4;
    localparam logic [7:0]  ERR_MAX   = 8'd255;

    // Word-aligned byte address: the two low bits never reach the counter.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder.
// slave is the encoder side, master is the requester/consumer side.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        base_load;
    logic [31:0] base_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_count;

    modport slave (
        input  in_valid, kind, rs, rt, rd, funct, imm, target,
               base_load, base_addr, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err, err_count
    );

    modport master (
        output in_valid, kind, rs, rt, rd, funct, imm, target,
               base_load, base_addr, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err, err_count
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational packing of an instruction class plus fields into a MIPS word.
// Classes 6 and 7 yield a zero word with the illegal flag set.
module instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the field layout by instruction class.
    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (kind)
            KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'd0, funct};
            KIND_LW:    word = {OP_LW, rs, rt, imm};
            KIND_SW:    word = {OP_SW, rs, rt, imm};
            KIND_BEQ:   word = {OP_BEQ, rs, rt, imm};
            KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
            KIND_J:     word = {OP_J, target};
            default: begin
                word    = 32'd0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: one-deep output register with valid/ready handshake,
// a word address counter and a saturating count of illegal requests.
module instr_encoder
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    instr_encoder_if.slave bus
);

    logic [31:0] word_s;
    logic        illegal_s;
    logic        in_ready_s;
    logic        accept_s;
    logic        transfer_s;
    logic [31:0] base_s;
    logic [31:0] emit_addr_s;

    logic        out_valid_r;
    logic [31:0] out_instr_r;
    logic [31:0] out_addr_r;
    logic [31:0] pc_next_r;
    logic        err_r;
    logic [7:0]  err_count_r;

    instr_pack u_pack (
        .kind    (bus.kind),
        .rs      (bus.rs),
        .rt      (bus.rt),
        .rd      (bus.rd),
        .funct   (bus.funct),
        .imm     (bus.imm),
        .target  (bus.target),
        .word    (word_s),
        .illegal (illegal_s)
    );

    // Ready depends only on held state and the consumer, never on in_valid.
    always_comb begin
        in_ready_s  = !out_valid_r || bus.out_ready;
        accept_s    = bus.in_valid && in_ready_s;
        transfer_s  = out_valid_r && bus.out_ready;
        base_s      = align_word(bus.base_addr);
        if (bus.base_load) begin
            emit_addr_s = base_s;
        end else begin
            emit_addr_s = pc_next_r;
        end
    end

    // Output register, address counter and error bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_instr_r <= 32'd0;
            out_addr_r  <= 32'd0;
            pc_next_r   <= 32'd0;
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            err_r <= 1'b0;
            if (accept_s && !illegal_s) begin
                out_valid_r <= 1'b1;
                out_instr_r <= word_s;
                out_addr_r  <= emit_addr_s;
                pc_next_r   <= emit_addr_s + ADDR_STEP;
            end else begin
                // An illegal request emits nothing, so it behaves as "no accept" here.
                if (transfer_s) begin
                    out_valid_r <= 1'b0;
                end
                if (bus.base_load) begin
                    pc_next_r <= base_s;
                end
            end
            if (accept_s && illegal_s) begin
                err_r <= 1'b1;
                if (err_count_r != ERR_MAX) begin
                    err_count_r <= err_count_r + 8'd1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_instr = out_instr_r;
    assign bus.out_addr  = out_addr_r;
    assign bus.err       = err_r;
    assign bus.err_count = err_count_r;

endmodule
